// File: rtl/thirty_two_to_eight_framer_pkg.sv
// Shared constants and FSM encoding for the 32->8 framer and its 8->32 partner.
package thirty_two_to_eight_framer_pkg;

   localparam int          PAYLOAD_W     = 12;
   localparam logic [3:0]  HDR_NIB_DEF   = 4'hA;
   localparam logic [15:0] TRAILER_DEF   = 16'hBEEF;
   localparam logic [7:0]  IDLE_BYTE_DEF = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } framer_state_e;

endpackage

// File: rtl/thirty_two_to_eight_framer_sync_fifo.sv
// Small synchronous FIFO; read data is valid combinationally from the head entry.
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             push_ok, pop_ok;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Qualify requests and advance pointers; pointers wrap because DEPTH is a power of 2.
   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   // Pointer and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/thirty_two_to_eight_framer.sv
// Buffers 12-bit payloads and streams {HDR, payload, TRAILER} MSB byte first with an idle gap.
module thirty_two_to_eight_framer
   import thirty_two_to_eight_framer_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter int          GAP_BYTES  = 1,
   parameter logic [7:0]  IDLE_BYTE  = IDLE_BYTE_DEF,
   parameter logic [3:0]  HDR_NIB    = HDR_NIB_DEF,
   parameter logic [15:0] TRAILER    = TRAILER_DEF,
   localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 div_8_clk,
   input  logic                 rst_n,
   // Handshake: a payload transfers on a rising edge where pl_valid && pl_ready; pl_ready
   // depends only on FIFO fullness, never on pl_valid.
   input  logic                 pl_valid,
   input  logic [PAYLOAD_W-1:0] pl_data,
   output logic                 pl_ready,
   output logic [7:0]           data_out,
   output logic                 byte_sof,
   output logic                 busy,
   output logic [LVL_W-1:0]     fifo_level
);

   localparam int GAP_W = (GAP_BYTES > 1) ? $clog2(GAP_BYTES) : 1;

   framer_state_e        state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [PAYLOAD_W-1:0] frame_q, frame_d;
   logic [7:0]           data_out_q, data_out_d;
   logic                 byte_sof_q, byte_sof_d;
   logic                 busy_q, busy_d;

   logic                 fifo_pop, fifo_full, fifo_empty;
   logic [PAYLOAD_W-1:0] fifo_rd_data;

   sync_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (div_8_clk),
      .rst_n   (rst_n),
      .push    (pl_valid),
      .pop     (fifo_pop),
      .wr_data (pl_data),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign pl_ready = !fifo_full;
   assign data_out = data_out_q;
   assign byte_sof = byte_sof_q;
   assign busy     = busy_q;

   // Next-state and next-byte selection; idle filler unless a frame byte is due.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      frame_d    = frame_q;
      data_out_d = IDLE_BYTE;
      byte_sof_d = 1'b0;
      busy_d     = 1'b0;
      fifo_pop   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               frame_d    = fifo_rd_data;
               data_out_d = {HDR_NIB, fifo_rd_data[11:8]};
               byte_sof_d = 1'b1;
               busy_d     = 1'b1;
               idx_d      = 2'd1;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            busy_d = 1'b1;
            idx_d  = idx_q + 2'd1;
            unique case (idx_q)
               2'd1:    data_out_d = frame_q[7:0];
               2'd2:    data_out_d = TRAILER[15:8];
               default: begin
                  data_out_d = TRAILER[7:0];
                  gap_d      = '0;
                  state_d    = ST_GAP;
               end
            endcase
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_BYTES - 1)) state_d = ST_IDLE;
            else                                gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters, frame register and registered outputs.
   always_ff @(posedge div_8_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         gap_q      <= '0;
         frame_q    <= '0;
         data_out_q <= IDLE_BYTE;
         byte_sof_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         frame_q    <= frame_d;
         data_out_q <= data_out_d;
         byte_sof_q <= byte_sof_d;
         busy_q     <= busy_d;
      end
   end

endmodule
